// File: rtl/vram_arbiter_if.sv
// Bundle of scan position, CPU write port, VRAM port and renderer outputs for vram_arbiter.
// slave is the arbiter side; master is the driver/observer side.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 4
);
  logic [9:0]        x_ptr;
  logic [9:0]        y_ptr;
  logic              valid;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              wr_full;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] tile_code;
  logic              tile_valid;
  logic              init_busy;

  modport slave (
    input  x_ptr, y_ptr, valid, wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, wr_full, mem_addr, mem_we, mem_wdata, tile_code, tile_valid, init_busy
  );

  modport master (
    output x_ptr, y_ptr, valid, wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, wr_full, mem_addr, mem_we, mem_wdata, tile_code, tile_valid, init_busy
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port tile VRAM arbiter: video tile fetch has priority, CPU writes drain from a FIFO.
// Optional power-on VRAM clear is enabled with `define VRAM_CLEAR_EN.
module vram_arbiter #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned COLS       = 40,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TILES = COLS * ROWS;

  // The whole tile map must be addressable.
  if (TILES > (1 << ADDR_W)) begin : g_bad_geometry
    $error("vram_arbiter: COLS*ROWS exceeds the VRAM address space");
  end

`ifdef VRAM_CLEAR_EN
  typedef enum logic [2:0] {INIT, IDLE, VREAD, VCAP, CWRITE} state_e;
  localparam state_e RST_STATE = INIT;
`else
  typedef enum logic [2:0] {IDLE, VREAD, VCAP, CWRITE} state_e;
  localparam state_e RST_STATE = IDLE;
`endif

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_full_q, wr_full_d;
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, mem_wdata_c;
  logic              mem_we_c;
  logic [DATA_W-1:0] tile_code_q, tile_code_d;
  logic              tile_valid_q, tile_valid_d;
  logic              slot_c, push_c, pop_c;
  logic [ADDR_W-1:0] vid_addr_c;
  logic              unused_y_msb;
`ifdef VRAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              init_busy_q, init_busy_d;
`endif

  // Rows are at most 32 (y_ptr[8:4]); the top scan-line bit never selects a tile.
  assign unused_y_msb = bus.y_ptr[9];

  assign slot_c     = bus.valid && (bus.x_ptr[3:0] == 4'd0);
  assign vid_addr_c = ADDR_W'(bus.y_ptr[8:4]) * ADDR_W'(COLS) + ADDR_W'(bus.x_ptr[9:4]);

  // Next-state, FIFO bookkeeping and VRAM port selection.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_addr_d  = fifo_addr_q;
    fifo_data_d  = fifo_data_q;
    mem_addr_c   = mem_addr_q;
    mem_wdata_c  = mem_wdata_q;
    mem_we_c     = 1'b0;
    pop_c        = 1'b0;
    push_c       = bus.wr_req && !wr_full_q && !reset;
    tile_code_d  = tile_code_q;
    tile_valid_d = (state_q == VREAD);
`ifdef VRAM_CLEAR_EN
    clr_cnt_d    = clr_cnt_q;
`endif

    // Read data for the slot issued last cycle is on mem_rdata now.
    if (state_q == VREAD) begin
      tile_code_d = bus.mem_rdata;
    end

    if (reset) begin
      state_d = RST_STATE;
    end
`ifdef VRAM_CLEAR_EN
    else if (state_q == INIT) begin
      mem_we_c    = 1'b1;
      mem_addr_c  = clr_cnt_q;
      mem_wdata_c = '0;
      clr_cnt_d   = clr_cnt_q + 1'b1;
      if (clr_cnt_q == ADDR_W'(TILES - 1)) begin
        state_d = IDLE;
      end
    end
`endif
    else if (slot_c) begin
      mem_addr_c = vid_addr_c;
      state_d    = VREAD;
    end else if (count_q != '0) begin
      pop_c       = 1'b1;
      mem_we_c    = 1'b1;
      mem_addr_c  = fifo_addr_q[rd_ptr_q];
      mem_wdata_c = fifo_data_q[rd_ptr_q];
      state_d     = CWRITE;
    end else begin
      state_d = (state_q == VREAD) ? VCAP : IDLE;
    end

    if (push_c) begin
      fifo_addr_d[wr_ptr_q] = bus.wr_addr;
      fifo_data_d[wr_ptr_q] = bus.wr_data;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    wr_full_d   = (count_d == CNT_W'(FIFO_DEPTH));
    mem_addr_d  = mem_addr_c;
    mem_wdata_d = mem_wdata_c;
`ifdef VRAM_CLEAR_EN
    init_busy_d = (state_d == INIT);
`endif
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RST_STATE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wr_full_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      tile_code_q  <= '0;
      tile_valid_q <= 1'b0;
`ifdef VRAM_CLEAR_EN
      clr_cnt_q    <= '0;
      init_busy_q  <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wr_full_q    <= wr_full_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      tile_code_q  <= tile_code_d;
      tile_valid_q <= tile_valid_d;
`ifdef VRAM_CLEAR_EN
      clr_cnt_q    <= clr_cnt_d;
      init_busy_q  <= init_busy_d;
`endif
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  assign bus.wr_ack     = push_c;
  assign bus.wr_full    = wr_full_q;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.tile_code  = tile_code_q;
  assign bus.tile_valid = tile_valid_q;
`ifdef VRAM_CLEAR_EN
  assign bus.init_busy  = init_busy_q;
`else
  assign bus.init_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed cases plus randomized traffic against a queue-based model.
// Works with or without VRAM_CLEAR_EN defined.
module tb_vram_arbiter;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned COLS   = 40;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned DEPTH  = 4;
  localparam int          TILES  = COLS * ROWS;
`ifdef VRAM_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Behavioural model state.
  wr_t               fifo_m[$];
  int                init_rem;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_wdata;
  logic [DATA_W-1:0] m_tile;
  logic              m_tile_valid;
  bit                slot_prev;
  bit                armed;
  int                n_checks;
  int                n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input int x, input int y,
                       input logic req, input int a, input int d, input int rd);
    @(negedge clk);
    reset         = rst;
    bus.valid     = v;
    bus.x_ptr     = 10'(x);
    bus.y_ptr     = 10'(y);
    bus.wr_req    = req;
    bus.wr_addr   = ADDR_W'(a);
    bus.wr_data   = DATA_W'(d);
    bus.mem_rdata = DATA_W'(rd);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1, 0, 1'b0, 0, 0, 0);
  endtask

  // Compare the current cycle against the model, then advance the model past the next edge.
  task automatic tick();
    int xi, yi, e_addr;
    bit slot, e_full, e_ack, e_we, pop, busy, issued;
    logic [DATA_W-1:0] e_wdata;
    xi      = int'(bus.x_ptr);
    yi      = int'(bus.y_ptr);
    slot    = bus.valid && (xi % 16 == 0);
    busy    = (init_rem > 0);
    e_full  = (fifo_m.size() == DEPTH);
    e_ack   = !reset && bus.wr_req && !e_full;
    e_we    = 1'b0;
    e_addr  = int'(last_addr);
    e_wdata = last_wdata;
    pop     = 1'b0;
    issued  = 1'b0;
    if (reset) begin
    end else if (busy) begin
      e_we    = 1'b1;
      e_addr  = TILES - init_rem;
      e_wdata = '0;
    end else if (slot) begin
      e_addr = (((yi % 512) / 16) * COLS + xi / 16) % (1 << ADDR_W);
      issued = 1'b1;
    end else if (fifo_m.size() > 0) begin
      e_we    = 1'b1;
      e_addr  = int'(fifo_m[0].a);
      e_wdata = fifo_m[0].d;
      pop     = 1'b1;
    end

    if (armed) begin
      chk("mem_we", 32'(bus.mem_we), 32'(e_we));
      chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      if (e_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
      chk("wr_ack", 32'(bus.wr_ack), 32'(e_ack));
      chk("wr_full", 32'(bus.wr_full), 32'(e_full));
      chk("tile_valid", 32'(bus.tile_valid), 32'(m_tile_valid));
      chk("tile_code", 32'(bus.tile_code), 32'(m_tile));
      chk("init_busy", 32'(bus.init_busy), 32'(busy));
    end

    if (reset) begin
      fifo_m.delete();
      last_addr    = '0;
      last_wdata   = '0;
      m_tile       = '0;
      m_tile_valid = 1'b0;
      slot_prev    = 1'b0;
      init_rem     = CLEAR ? TILES : 0;
      armed        = 1'b1;
    end else begin
      if (busy) init_rem--;
      if (pop) void'(fifo_m.pop_front());
      if (e_ack) fifo_m.push_back('{a: bus.wr_addr, d: bus.wr_data});
      last_addr    = ADDR_W'(e_addr);
      last_wdata   = e_wdata;
      m_tile_valid = slot_prev;
      if (slot_prev) m_tile = bus.mem_rdata;
      slot_prev    = issued;
    end
  endtask

  task automatic drain_init();
    while (init_rem > 0) begin
      idle();
      tick();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    armed    = 1'b0;
    init_rem = 0;
    reset    = 1'b1;
    bus.valid = 1'b0; bus.x_ptr = '0; bus.y_ptr = '0; bus.wr_req = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.mem_rdata = '0;

    // Reset with idle inputs.
    drive(1'b1, 1'b0, 1, 0, 1'b0, 0, 0, 0); tick();
    drive(1'b1, 1'b0, 1, 0, 1'b0, 0, 0, 0); tick();
    idle();
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_tile_code", 32'(bus.tile_code), 0);
    chk("rst_tile_valid", 32'(bus.tile_valid), 0);
    chk("rst_wr_full", 32'(bus.wr_full), 0);
    chk("rst_wr_ack", 32'(bus.wr_ack), 0);
`ifdef VRAM_CLEAR_EN
    chk("clr_first_we", 32'(bus.mem_we), 1);
    chk("clr_init_busy", 32'(bus.init_busy), 1);
    tick();
    drain_init();
    idle();
    chk("clr_done_busy", 32'(bus.init_busy), 0);
    chk("clr_done_we", 32'(bus.mem_we), 0);
    chk("clr_done_addr", 32'(bus.mem_addr), 1199);
`else
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_init_busy", 32'(bus.init_busy), 0);
`endif
    tick();

    // Single CPU write, no video.
    drive(1'b0, 1'b0, 1, 0, 1'b1, 5, 3, 0);
    chk("wr5_ack", 32'(bus.wr_ack), 1);
    chk("wr5_no_bypass", 32'(bus.mem_we), 0);
    tick();
    idle();
    chk("wr5_we", 32'(bus.mem_we), 1);
    chk("wr5_addr", 32'(bus.mem_addr), 5);
    chk("wr5_data", 32'(bus.mem_wdata), 3);
    tick();

    // Buffered write meets a video slot; then read latency.
    drive(1'b0, 1'b0, 1, 0, 1'b1, 7, 6, 0); tick();
    drive(1'b0, 1'b1, 32, 48, 1'b0, 0, 0, 0);
    chk("slot_addr", 32'(bus.mem_addr), 122);
    chk("slot_we", 32'(bus.mem_we), 0);
    tick();
    drive(1'b0, 1'b1, 33, 48, 1'b0, 0, 0, 9);
    chk("after_slot_we", 32'(bus.mem_we), 1);
    chk("after_slot_addr", 32'(bus.mem_addr), 7);
    chk("slot1_tile_valid", 32'(bus.tile_valid), 0);
    tick();
    drive(1'b0, 1'b1, 34, 48, 1'b0, 0, 0, 2);
    chk("slot2_tile_valid", 32'(bus.tile_valid), 1);
    chk("slot2_tile_code", 32'(bus.tile_code), 9);
    tick();
    drive(1'b0, 1'b1, 35, 48, 1'b0, 0, 0, 4);
    chk("slot3_tile_valid", 32'(bus.tile_valid), 0);
    chk("slot3_tile_hold", 32'(bus.tile_code), 9);
    tick();

    // Fill FIFO during back-to-back slots; full refuses even when popping.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 0, 0, 1'b1, 10 + i, i, i);
      chk("fill_ack", 32'(bus.wr_ack), 1);
      tick();
    end
    drive(1'b0, 1'b1, 0, 0, 1'b1, 14, 4, 0);
    chk("full_flag", 32'(bus.wr_full), 1);
    chk("full_refuse", 32'(bus.wr_ack), 0);
    tick();
    drive(1'b0, 1'b0, 1, 0, 1'b1, 14, 4, 0);
    chk("full_pop_refuse", 32'(bus.wr_ack), 0);
    chk("full_pop_addr", 32'(bus.mem_addr), 10);
    tick();
    for (int i = 1; i < 4; i++) begin
      idle();
      chk("drain_addr", 32'(bus.mem_addr), 32'(10 + i));
      chk("drain_data", 32'(bus.mem_wdata), 32'(i));
      tick();
    end
    idle(); tick();

    // Reset discards buffered writes.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 0, 0, 1'b1, 20 + i, 1, 0); tick();
    end
    drive(1'b1, 1'b1, 0, 0, 1'b0, 0, 0, 0);
    chk("mid_rst_we", 32'(bus.mem_we), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("post_rst_full", 32'(bus.wr_full), 0);
      chk("post_rst_we", 32'(bus.mem_we), 32'(CLEAR));
      tick();
    end
`ifdef VRAM_CLEAR_EN
    // Pushes accepted during the clear but held until it finishes.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1, 0, 1'b1, 1300 + i, 8 + i, 0);
      chk("init_push_ack", 32'(bus.wr_ack), (i < 4) ? 1 : 0);
      tick();
    end
    idle();
    chk("init_full", 32'(bus.wr_full), 1);
    tick();
    drain_init();
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("init_order_addr", 32'(bus.mem_addr), 32'(1300 + i));
      chk("init_order_data", 32'(bus.mem_wdata), 32'(8 + i));
      tick();
    end
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic r, v, q;
      int x;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) < 7);
      q = ($urandom_range(0, 9) < 5);
      x = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 63)) * 16 : int'($urandom_range(0, 1023));
      drive(r, v, x, int'($urandom_range(0, 1023)), q, int'($urandom_range(0, 2047)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, meaning the tile VRAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 4, meaning the tile code width.
REQ-003 The block SHALL have parameter COLS, default 40, meaning the tiles per row (16x16 tiles on 640x480).
REQ-004 The block SHALL have parameter ROWS, default 30, meaning the tile rows.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the CPU write buffer entries (power of two).
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock (pixel clock), with all logic on the rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, a synchronous, active-high reset.
REQ-008 The block SHALL have ports x_ptr and y_ptr, input, 10 bits each, the current scan position from the VGA timing block.
REQ-009 The block SHALL have port valid, input, 1 bit, high in the active video region.
REQ-010 The block SHALL have ports wr_req (input, 1 bit), wr_addr (input, ADDR_W), wr_data (input, DATA_W) and wr_ack (output, 1 bit), forming the CPU/game-logic write port.
REQ-011 The block SHALL have port wr_full, output, 1 bit, high while the write buffer holds FIFO_DEPTH entries.
REQ-012 The block SHALL have ports mem_addr (output, ADDR_W), mem_we (output, 1 bit), mem_wdata (output, DATA_W) and mem_rdata (input, DATA_W), driving a single-port VRAM with 1-cycle read latency.
REQ-013 The block SHALL have ports tile_code (output, DATA_W) and tile_valid (output, 1 bit), the fetched tile for the renderer.
REQ-014 The block SHALL have port init_busy, output, 1 bit, high during the power-on clear.

Function
REQ-015 The block SHALL define a video slot as any cycle with valid=1 and x_ptr[3:0]=0.
REQ-016 In a video slot, the block SHALL drive mem_addr = y_ptr[8:4]*COLS + x_ptr[9:4] and mem_we=0; the video slot always wins over CPU writes.
REQ-017 The block SHALL register mem_rdata into tile_code at the edge ending slot+1 and pulse tile_valid for exactly one cycle (slot+2), giving a fixed 2-cycle latency.
REQ-018 The block SHALL assert wr_ack combinationally as wr_req && !wr_full, and push (wr_addr, wr_data) into the FIFO on that edge.
REQ-019 When wr_full=1, the block SHALL refuse wr_req even if a pop occurs in the same cycle, because full is evaluated on the current count.
REQ-020 In any non-slot cycle with the FIFO non-empty and init_busy=0, the block SHALL pop the head and drive mem_we=1, mem_addr and mem_wdata from the popped entry, in FIFO order.
REQ-021 The block SHALL provide no same-cycle bypass; a write pushed into an empty FIFO reaches VRAM no earlier than the next cycle.
REQ-022 The block SHALL implement a control FSM with states INIT, IDLE, VREAD (slot issued), VCAP (capture rdata) and CWRITE; a slot in VCAP re-enters VREAD directly.
REQ-023 The block SHALL hold the previous tile_code value when no slot occurs, and hold mem_addr at its last value with mem_we=0 when idle.
REQ-024 The block SHALL not check wr_addr values at or above COLS*ROWS and SHALL pass them to VRAM unchanged.

Reset
REQ-025 When reset=1, the block SHALL empty the FIFO and set wr_full=0, mem_we=0, mem_addr=0, mem_wdata=0, tile_code=0 and tile_valid=0 on the next edge.
REQ-026 Reset asserted mid-operation SHALL discard buffered writes and any in-flight video read, with no partial VRAM write.
REQ-027 After reset, the FSM SHALL enter INIT if VRAM_CLEAR_EN is defined and IDLE otherwise.

Configuration
REQ-028 With macro VRAM_CLEAR_EN defined, the block SHALL hold init_busy=1 after reset for COLS*ROWS cycles and write 0 to addresses 0..COLS*ROWS-1 in ascending order, one per cycle, suppressing video slots.
REQ-029 With VRAM_CLEAR_EN defined, the FIFO SHALL still accept pushes during INIT but SHALL not pop until init_busy=0.
REQ-030 With VRAM_CLEAR_EN undefined, the block SHALL tie init_busy to 0, omit the INIT state, and keep VRAM contents unchanged after reset.

Verification
REQ-031 The bench SHALL check: reset pulse, idle inputs -> all outputs 0; with VRAM_CLEAR_EN, mem_we=1 with addresses 0..1199 over 1200 cycles, then init_busy=0.
REQ-032 The bench SHALL check: valid=0, wr_req with addr=5, data=3 -> wr_ack=1, then next cycle mem_we=1, mem_addr=5, mem_wdata=3.
REQ-033 The bench SHALL check: one buffered write while x_ptr=32, y_ptr=48, valid=1 -> mem_addr=122, mem_we=0 that cycle, and the write issues the following cycle.
REQ-034 The bench SHALL check: mem_rdata=9 at slot+1 -> tile_code=9 and tile_valid=1 only at slot+2.
REQ-035 The bench SHALL check (VRAM_CLEAR_EN): 5 pushes during INIT -> first 4 acked, wr_full=1, fifth wr_ack=0; after INIT, 4 writes in push order.
REQ-036 The bench SHALL check: reset with 3 entries buffered -> wr_full=0, no mem_we for those entries after release.
